// File: rtl/string_gen.sv
`default_nettype none
// string_gen: emits "D s D s ... D" ASCII streams over a valid/ready handshake.
// Revision 1.0
module string_gen #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [3:0]       seed,
   input  logic [7:0]       sep,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIGIT = 2'd1,
      SEP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [3:0]       digit;
   logic [7:0]       sep_q;

   logic             xfer;
   logic             bad_start;
   logic [3:0]       digit_inc;

   assign xfer      = out_valid & out_ready;
   assign bad_start = (len == '0) || (seed > 4'd9) || ((sep >= 8'h30) && (sep <= 8'h39));
   assign digit_inc = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         remaining <= '0;
         digit     <= 4'd0;
         sep_q     <= 8'h00;
         out_char  <= 8'h00;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // done/err are single-cycle pulses unless re-armed below
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (bad_start) begin
                     err <= 1'b1;
                  end else begin
                     state     <= DIGIT;
                     remaining <= len;
                     digit     <= seed;
                     sep_q     <= sep;
                     out_char  <= 8'h30 + {4'h0, seed};
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
            end
            DIGIT: begin
               if (xfer) begin
                  if (remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state     <= SEP;
                     out_char  <= sep_q;
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            SEP: begin
               if (xfer) begin
                  state    <= DIGIT;
                  digit    <= digit_inc;
                  out_char <= 8'h30 + {4'h0, digit_inc};
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
